// File: rtl/arb8_1_16_pkg.sv
// arb8_1_16_pkg: shared sizes, select type and round-robin pick function
package arb8_1_16_pkg;
  localparam int NREQ = 8;
  localparam int DW = 16;
  localparam int SELW = 3;
  typedef logic [SELW-1:0] sel_t;
  function automatic sel_t rr_pick(input logic [NREQ-1:0] req, input sel_t ptr);
    logic [2*NREQ-1:0] dbl;
    sel_t off;
    dbl = {req, req} >> (4'(ptr) + 4'd1);
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) if (dbl[i]) off = sel_t'(i);
    return ptr + off + sel_t'(1);
  endfunction
endpackage

// File: rtl/arb8_1_16_if.sv
// arb8_1_16_if: requester words, grant and valid/ready output bus
interface arb8_1_16_if;
  import arb8_1_16_pkg::*;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant;
  logic [DW-1:0] InA, InB, InC, InD, InE, InF, InG, InH;
  logic out_ready;
  logic out_valid;
  logic [DW-1:0] Out;
  sel_t out_src;
  modport master(output req, InA, InB, InC, InD, InE, InF, InG, InH, out_ready,
                 input grant, out_valid, Out, out_src);
  modport slave(input req, InA, InB, InC, InD, InE, InF, InG, InH, out_ready,
                output grant, out_valid, Out, out_src);
endinterface

// File: rtl/mux8_1_16.sv
// mux8_1_16: 16-bit 8:1 data select
module mux8_1_16
  import arb8_1_16_pkg::*;
(
  input  sel_t S,
  input  logic [DW-1:0] InA, InB, InC, InD, InE, InF, InG, InH,
  output logic [DW-1:0] Y
);
  // binary tree of 2:1 selects on S
  always_comb
    Y = S[2] ? (S[1] ? (S[0] ? InH : InG) : (S[0] ? InF : InE))
             : (S[1] ? (S[0] ? InD : InC) : (S[0] ? InB : InA));
endmodule

// File: rtl/arb8_1_16.sv
// arb8_1_16: round-robin arbiter feeding a 1-entry valid/ready output register
module arb8_1_16
  import arb8_1_16_pkg::*;
#(
  parameter sel_t RST_PTR = 3'd7
) (
  input logic clk,
  input logic rst,
  arb8_1_16_if.slave bus
);
  sel_t ptr, sel, src_q;
  logic valid_q, free, accept;
  logic [DW-1:0] word, out_q;
  assign free = !valid_q | bus.out_ready;
  assign accept = free & (|bus.req) & !rst;
  assign sel = rr_pick(bus.req, ptr);
  assign bus.grant = accept ? NREQ'(1) << sel : '0;
  assign bus.out_valid = valid_q;
  assign bus.Out = out_q;
  assign bus.out_src = src_q;
  mux8_1_16 u_mux (
    .S(sel), .InA(bus.InA), .InB(bus.InB), .InC(bus.InC), .InD(bus.InD),
    .InE(bus.InE), .InF(bus.InF), .InG(bus.InG), .InH(bus.InH), .Y(word)
  );
  // load the granted word, empty the stage when drained, hold everything on stall
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_q <= 1'b0;
      out_q <= '0;
      src_q <= '0;
      ptr <= RST_PTR;
    end else if (accept) begin
      valid_q <= 1'b1;
      out_q <= word;
      src_q <= sel;
      ptr <= sel;
    end else if (free) valid_q <= 1'b0;
endmodule

// File: tb/tb_arb8_1_16.sv
// tb_arb8_1_16: scoreboard bench for the round-robin arbiter
module tb_arb8_1_16;
  import arb8_1_16_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [15:0] words [8];
  logic [18:0] sb [$];
  logic [18:0] exp_w;
  logic mvalid, mfree, macc;
  sel_t mptr, msel;
  logic [7:0] exp_grant;

  arb8_1_16_if bus();
  arb8_1_16 dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  assign bus.InA = words[0];
  assign bus.InB = words[1];
  assign bus.InC = words[2];
  assign bus.InD = words[3];
  assign bus.InE = words[4];
  assign bus.InF = words[5];
  assign bus.InG = words[6];
  assign bus.InH = words[7];

  // consumed words are popped from the scoreboard and compared
  always @(negedge clk) begin
    #2;
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow: got src=%0d Out=%h, no word expected", bus.out_src, bus.Out);
      end else begin
        exp_w = sb.pop_front();
        if ({bus.out_src, bus.Out} !== exp_w) begin
          failures++;
          $display("FAIL sb_word: got src=%0d Out=%h, expected src=%0d Out=%h",
                   bus.out_src, bus.Out, exp_w[18:16], exp_w[15:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic sel_t model_pick(input logic [7:0] r, input sel_t p);
    sel_t s = p;
    for (int k = 8; k >= 1; k--) if (r[(int'(p) + k) % 8]) s = sel_t'((int'(p) + k) % 8);
    return s;
  endfunction

  task automatic model_reset();
    mvalid = 1'b0;
    mptr = 3'd7;
    macc = 1'b0;
    mfree = 1'b1;
    sb.delete();
  endtask

  task automatic drive(input logic [7:0] r, input logic rdy);
    bus.req = r;
    bus.out_ready = rdy;
    #1;
    mfree = !mvalid || rdy;
    macc = mfree && (r != 8'h00);
    msel = model_pick(r, mptr);
    exp_grant = macc ? 8'(1) << msel : 8'h00;
    if (macc) sb.push_back({msel, words[msel]});
  endtask

  task automatic advance();
    @(posedge clk);
    if (macc) begin
      mvalid = 1'b1;
      mptr = msel;
    end else if (mfree) mvalid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    bus.req = 8'hFF;
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.Out !== 16'h0000) begin failures++; $display("FAIL rst_out: got %h expected 0000", bus.Out); end
    checks++; if (bus.out_src !== 3'd0) begin failures++; $display("FAIL rst_src: got %0d expected 0", bus.out_src); end
    checks++; if (bus.grant !== 8'h00) begin failures++; $display("FAIL rst_grant: got %h expected 00", bus.grant); end
    bus.req = 8'h00;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 8; i++) words[i] = 16'hA000 + 16'(i);
    for (int k = 0; k < 10; k++) begin
      drive(8'hFF, 1'b1);
      checks++; if (bus.grant !== exp_grant) begin failures++; $display("FAIL rr_grant: got %h expected %h", bus.grant, exp_grant); end
      advance();
      checks++; if (bus.out_src !== 3'(k % 8) || bus.out_valid !== 1'b1) begin failures++; $display("FAIL rr_src: got src=%0d valid=%b expected src=%0d valid=1", bus.out_src, bus.out_valid, k % 8); end
    end
    drive(8'h00, 1'b1);
    advance();
  endtask

  task automatic test_single_and_drain();
    words[3] = 16'hBEEF;
    drive(8'h08, 1'b1);
    checks++; if (bus.grant !== 8'h08) begin failures++; $display("FAIL single_grant: got %h expected 08", bus.grant); end
    advance();
    drive(8'h00, 1'b1);
    checks++; if (bus.out_valid !== 1'b1 || bus.Out !== 16'hBEEF || bus.out_src !== 3'd3) begin failures++; $display("FAIL single_out: got valid=%b Out=%h src=%0d expected 1 BEEF 3", bus.out_valid, bus.Out, bus.out_src); end
    advance();
    checks++; if (bus.out_valid !== 1'b0 || bus.Out !== 16'hBEEF) begin failures++; $display("FAIL drain: got valid=%b Out=%h expected 0 BEEF", bus.out_valid, bus.Out); end
  endtask

  task automatic test_stall();
    words[3] = 16'h1234;
    drive(8'h08, 1'b1);
    advance();
    words[0] = 16'h0A0A;
    words[2] = 16'h0C0C;
    for (int k = 0; k < 3; k++) begin
      drive(8'h05, 1'b0);
      checks++; if (bus.grant !== 8'h00 || bus.Out !== 16'h1234 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL stall: got grant=%h Out=%h valid=%b expected 00 1234 1", bus.grant, bus.Out, bus.out_valid); end
      advance();
    end
    drive(8'h05, 1'b1);
    checks++; if (bus.grant !== 8'h01 || exp_grant !== 8'h01) begin failures++; $display("FAIL stall_release: got %h expected 01", bus.grant); end
    advance();
    checks++; if (bus.out_valid !== 1'b1 || bus.Out !== 16'h0A0A || bus.out_src !== 3'd0) begin failures++; $display("FAIL no_bubble: got valid=%b Out=%h src=%0d expected 1 0A0A 0", bus.out_valid, bus.Out, bus.out_src); end
    drive(8'h04, 1'b1);
    checks++; if (bus.grant !== 8'h04) begin failures++; $display("FAIL stall_pending: got %h expected 04", bus.grant); end
    advance();
    drive(8'h00, 1'b1);
    advance();
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
    words[0] = 16'h0000;
    words[7] = 16'h7777;
    for (int k = 0; k < 3; k++) begin
      drive(8'h81, 1'b1);
      checks++; if (bus.grant !== (k == 1 ? 8'h80 : 8'h01) || bus.grant !== exp_grant) begin failures++; $display("FAIL wrap_grant: got %h expected %h", bus.grant, k == 1 ? 8'h80 : 8'h01); end
      advance();
    end
    drive(8'h00, 1'b1);
    advance();
  endtask

  task automatic test_async_reset();
    words[5] = 16'h5555;
    words[6] = 16'h6666;
    drive(8'h20, 1'b1);
    advance();
    drive(8'h20, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.Out !== 16'h0000 || bus.out_src !== 3'd0) begin failures++; $display("FAIL async_rst: got valid=%b Out=%h src=%0d expected 0 0000 0", bus.out_valid, bus.Out, bus.out_src); end
    checks++; if (bus.grant !== 8'h00) begin failures++; $display("FAIL async_rst_grant: got %h expected 00", bus.grant); end
    model_reset();
    bus.req = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    drive(8'h41, 1'b1);
    checks++; if (bus.grant !== 8'h01) begin failures++; $display("FAIL rearb: got %h expected 01", bus.grant); end
    advance();
    drive(8'h40, 1'b1);
    advance();
    drive(8'h00, 1'b1);
    advance();
  endtask

  task automatic test_random();
    logic [7:0] r, g, hold;
    r = 8'h00;
    g = 8'h00;
    for (int n = 0; n < 72; n++) begin
      hold = r & ~g;
      for (int i = 0; i < 8; i++) if (!hold[i]) words[i] = 16'($urandom);
      r = n < 60 ? hold | 8'($urandom) : hold;
      drive(r, n < 60 ? 1'($urandom_range(0, 3) != 0) : 1'b1);
      checks++; if (bus.grant !== exp_grant) begin failures++; $display("FAIL rand_grant: cycle %0d got %h expected %h", n, bus.grant, exp_grant); end
      g = bus.grant;
      advance();
      checks++; if (bus.out_valid !== mvalid) begin failures++; $display("FAIL rand_valid: cycle %0d got %b expected %b", n, bus.out_valid, mvalid); end
    end
    drive(8'h00, 1'b1);
    advance();
    checks++; if (sb.size() != 0 || r & ~g) begin failures++; $display("FAIL sb_leftover: %0d words pending, req %h", sb.size(), r & ~g); end
  endtask

  initial begin
    bus.req = 8'h00;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) words[i] = 16'h0000;
    model_reset();
    test_reset();
    test_round_robin();
    test_single_and_drain();
    test_stall();
    test_wrap();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
